// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: next-PC select encodings, the NOP word,
// default vector addresses and the supervisor-preserving PC increment.
package pipeline_pkg;

  // Next-PC select encoding shared with the control unit; 110/111 fall
  // back to sequential fetch.
  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'b000,
    PCSRC_BRANCH = 3'b001,
    PCSRC_JUMP   = 3'b010,
    PCSRC_JR     = 3'b011,
    PCSRC_ILLOP  = 3'b100,
    PCSRC_XADR   = 3'b101
  } pcsrc_e;

  // sll $0,$0,0 -- the canonical bubble word.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEFAULT_XADR_VEC  = 32'h8000_0008;

  // Bit 31 is the supervisor bit: the increment never carries into it,
  // the low 31 bits wrap on their own.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Write-enable beats flush so a stalled
// instruction in ID is never thrown away; a flush loads a NOP bubble.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_en,
  input  logic        flush,
  input  logic [31:0] inst,
  input  logic [31:0] pc_plus4,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  // Load the fetched word, a bubble, or hold, by write/flush priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      id_inst     <= NOP_INST;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else if (write_en) begin
      if (flush) begin
        id_inst     <= NOP_INST;
        id_pc_plus4 <= pc_plus4;
        id_valid    <= 1'b0;
      end else begin
        id_inst     <= inst;
        id_pc_plus4 <= pc_plus4;
        id_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, prioritised next-PC selection,
// a redirect latch that survives PCWrite stalls, and the IF/ID register.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] ILLOP_VEC = DEFAULT_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEFAULT_XADR_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_write,
  input  logic        IF_ID_flush,
  input  logic [2:0]  ID_PCSrc,
  input  logic [2:0]  ID_EX_PCSrc,
  input  logic        EX_ALUOut0,
  input  logic [25:0] ID_JumpTarget,
  input  logic [31:0] ID_RegRs,
  input  logic [31:0] EX_BranchTarget,
  output logic [31:0] IF_PC,
  input  logic [31:0] IF_Inst,
  output logic [31:0] IF_ID_Inst,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
);

  logic [31:0] pc;
  logic [31:0] seq_pc;
  logic [31:0] id_target;
  logic [31:0] next_pc;
  logic [31:0] pending_pc;
  logic        pending_valid;
  logic        branch_taken;
  logic        id_redirect;
  logic        redirect;
  logic        bubble;

  assign IF_PC        = pc;
  assign seq_pc       = pc_plus4(pc);
  assign branch_taken = (ID_EX_PCSrc == PCSRC_BRANCH) && EX_ALUOut0;

  // Decode the ID-stage redirect request and its target address.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    id_redirect = 1'b1;
    id_target   = seq_pc;
    case (ID_PCSrc)
      PCSRC_JUMP:  id_target = {IF_ID_PCPlus4[31:28], ID_JumpTarget, 2'b00};
      PCSRC_JR:    id_target = ID_RegRs;
      PCSRC_ILLOP: id_target = ILLOP_VEC;
      PCSRC_XADR:  id_target = XADR_VEC;
      default:     id_redirect = 1'b0;
    endcase
  end

  // A taken branch in EX is older than anything in ID, so it wins.
  assign redirect = branch_taken || id_redirect;
  assign next_pc  = branch_taken ? EX_BranchTarget : id_target;

  // Anything fetched while a redirect is live or pending is wrong-path.
  assign bubble = IF_ID_flush || pending_valid || redirect;

  // PC update and redirect latch: capture redirects seen during a stall,
  // apply them on the first cycle the PC is allowed to move.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc            <= RESET_PC;
      pending_valid <= 1'b0;
      pending_pc    <= RESET_PC;
    end else if (PCWrite) begin
      if (branch_taken)       pc <= EX_BranchTarget;
      else if (pending_valid) pc <= pending_pc;
      else                    pc <= next_pc;
      pending_valid <= 1'b0;
    end else if (branch_taken || (id_redirect && !pending_valid)) begin
      // A held ID redirect repeats every stalled cycle; only a branch
      // may replace one that is already latched.
      pending_valid <= 1'b1;
      pending_pc    <= next_pc;
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .rst_n       (reset),
    .write_en    (IF_ID_write),
    .flush       (bubble),
    .inst        (IF_Inst),
    .pc_plus4    (seq_pc),
    .id_inst     (IF_ID_Inst),
    .id_pc_plus4 (IF_ID_PCPlus4),
    .id_valid    (IF_ID_Valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table walking the
// documented scenarios, a hand-written stall sequence, and a randomized
// run compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        IF_ID_write;
  logic        IF_ID_flush;
  logic [2:0]  ID_PCSrc;
  logic [2:0]  ID_EX_PCSrc;
  logic        EX_ALUOut0;
  logic [25:0] ID_JumpTarget;
  logic [31:0] ID_RegRs;
  logic [31:0] EX_BranchTarget;
  logic [31:0] IF_PC;
  logic [31:0] IF_Inst;
  logic [31:0] IF_ID_Inst;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Instruction ROM contents: an address-dependent word.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign IF_Inst = rom(IF_PC);

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .PCWrite         (PCWrite),
    .IF_ID_write     (IF_ID_write),
    .IF_ID_flush     (IF_ID_flush),
    .ID_PCSrc        (ID_PCSrc),
    .ID_EX_PCSrc     (ID_EX_PCSrc),
    .EX_ALUOut0      (EX_ALUOut0),
    .ID_JumpTarget   (ID_JumpTarget),
    .ID_RegRs        (ID_RegRs),
    .EX_BranchTarget (EX_BranchTarget),
    .IF_PC           (IF_PC),
    .IF_Inst         (IF_Inst),
    .IF_ID_Inst      (IF_ID_Inst),
    .IF_ID_PCPlus4   (IF_ID_PCPlus4),
    .IF_ID_Valid     (IF_ID_Valid)
  );

  typedef struct {
    bit          rst;
    bit          pcw;
    bit          ifw;
    bit          fl;
    logic [2:0]  id_src;
    logic [2:0]  ex_src;
    bit          alu0;
    logic [25:0] jt;
    logic [31:0] rs;
    logic [31:0] bt;
    logic [31:0] exp_pc;
    bit          exp_valid;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_pc4 = 32'h0;
  bit          m_valid = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit pcw, input bit ifw, input bit fl,
                              input logic [2:0] id_src, input logic [2:0] ex_src, input bit alu0,
                              input logic [25:0] jt, input logic [31:0] rs, input logic [31:0] bt,
                              input logic [31:0] exp_pc, input bit exp_valid,
                              input logic [31:0] exp_pc4);
    vec_t v;
    v.rst = rst; v.pcw = pcw; v.ifw = ifw; v.fl = fl;
    v.id_src = id_src; v.ex_src = ex_src; v.alu0 = alu0;
    v.jt = jt; v.rs = rs; v.bt = bt;
    v.exp_pc = exp_pc; v.exp_valid = exp_valid; v.exp_pc4 = exp_pc4;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    reset           = v.rst;
    PCWrite         = v.pcw;
    IF_ID_write     = v.ifw;
    IF_ID_flush     = v.fl;
    ID_PCSrc        = v.id_src;
    ID_EX_PCSrc     = v.ex_src;
    EX_ALUOut0      = v.alu0;
    ID_JumpTarget   = v.jt;
    ID_RegRs        = v.rs;
    EX_BranchTarget = v.bt;
  endtask

  // One clock edge of the fetch rules, from the inputs present at the edge.
  task automatic model_edge();
    bit          taken;
    bit          has;
    logic [31:0] tgt;
    logic [31:0] seq;
    if (!reset) begin
      m_pc = 32'h8000_0000; m_pend = 1'b0;
      m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      seq   = ((m_pc + 32'd4) & 32'h7FFF_FFFF) | (m_pc & 32'h8000_0000);
      taken = (ID_EX_PCSrc == 3'b001) && EX_ALUOut0;
      has   = 1'b1;
      tgt   = 32'h0;
      case (ID_PCSrc)
        3'b010:  tgt = {m_pc4[31:28], ID_JumpTarget, 2'b00};
        3'b011:  tgt = ID_RegRs;
        3'b100:  tgt = 32'h8000_0004;
        3'b101:  tgt = 32'h8000_0008;
        default: has = 1'b0;
      endcase
      if (taken) begin has = 1'b1; tgt = EX_BranchTarget; end
      if (IF_ID_write) begin
        m_pc4 = seq;
        if (IF_ID_flush || m_pend || has) begin m_inst = 32'h0; m_valid = 1'b0; end
        else begin m_inst = rom(m_pc); m_valid = 1'b1; end
      end
      if (PCWrite) begin
        if (taken)       m_pc = tgt;
        else if (m_pend) m_pc = m_pend_pc;
        else if (has)    m_pc = tgt;
        else             m_pc = seq;
        m_pend = 1'b0;
      end else if (taken || (has && !m_pend)) begin
        m_pend = 1'b1; m_pend_pc = tgt;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_if_pc", IF_PC, m_pc);
    check("model_inst", IF_ID_Inst, m_inst);
    check("model_pc4", IF_ID_PCPlus4, m_pc4);
    check("model_valid", {31'b0, IF_ID_Valid}, {31'b0, m_valid});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // rst pcw ifw fl id ex alu jt rs bt | exp_pc valid exp_pc4
    vecs.push_back(mk(0,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0000,0,32'h0));
    vecs.push_back(mk(0,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0000,0,32'h0));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0004,1,32'h8000_0004));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0008,1,32'h8000_0008));
    vecs.push_back(mk(1,1,1,1,3'd3,3'd0,0,26'h0,32'h0040_000C,32'h0, 32'h0040_000C,0,32'h8000_000C));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h0040_0010,1,32'h0040_0010));
    vecs.push_back(mk(1,1,1,1,3'd2,3'd0,0,26'h40,32'h0,32'h0, 32'h0000_0100,0,32'h0040_0014));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h0000_0104,1,32'h0000_0104));
    vecs.push_back(mk(1,1,1,1,3'd2,3'd1,1,26'h40,32'h0,32'h0040_0200, 32'h0040_0200,0,32'h0000_0108));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd1,0,26'h0,32'h0,32'h1234_5678, 32'h0040_0204,1,32'h0040_0204));
    vecs.push_back(mk(1,0,0,1,3'd3,3'd0,0,26'h0,32'h0040_0080,32'h0, 32'h0040_0204,1,32'h0040_0204));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h0040_0080,0,32'h0040_0208));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h0040_0084,1,32'h0040_0084));
    vecs.push_back(mk(1,0,1,0,3'd4,3'd0,0,26'h0,32'h0,32'h0, 32'h0040_0084,0,32'h0040_0088));
    vecs.push_back(mk(1,0,1,0,3'd0,3'd1,1,26'h0,32'h0,32'h0040_0300, 32'h0040_0084,0,32'h0040_0088));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h0040_0300,0,32'h0040_0088));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h0040_0304,1,32'h0040_0304));
    vecs.push_back(mk(1,0,1,0,3'd5,3'd0,0,26'h0,32'h0,32'h0, 32'h0040_0304,0,32'h0040_0308));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd1,1,26'h0,32'h0,32'h0040_0400, 32'h0040_0400,0,32'h0040_0308));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h0040_0404,1,32'h0040_0404));
    vecs.push_back(mk(1,1,1,1,3'd4,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0004,0,32'h0040_0408));
    vecs.push_back(mk(1,1,1,1,3'd5,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0008,0,32'h8000_0008));
    vecs.push_back(mk(1,1,1,0,3'd6,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_000C,1,32'h8000_000C));
    vecs.push_back(mk(1,1,1,0,3'd7,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0010,1,32'h8000_0010));
    vecs.push_back(mk(1,0,0,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0010,1,32'h8000_0010));
    vecs.push_back(mk(1,0,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0010,1,32'h8000_0014));
    vecs.push_back(mk(1,1,0,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0014,1,32'h8000_0014));
    vecs.push_back(mk(1,1,1,1,3'd3,3'd0,0,26'h0,32'h7FFF_FFFC,32'h0, 32'h7FFF_FFFC,0,32'h8000_0018));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h0000_0000,1,32'h0000_0000));
    vecs.push_back(mk(1,1,1,1,3'd3,3'd0,0,26'h0,32'hFFFF_FFFC,32'h0, 32'hFFFF_FFFC,0,32'h0000_0004));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0000,1,32'h8000_0000));
    vecs.push_back(mk(1,0,1,0,3'd3,3'd0,0,26'h0,32'h0040_1000,32'h0, 32'h8000_0000,0,32'h8000_0004));
    vecs.push_back(mk(0,0,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0000,0,32'h0));
    vecs.push_back(mk(1,1,1,0,3'd0,3'd0,0,26'h0,32'h0,32'h0, 32'h8000_0004,1,32'h8000_0004));

    apply(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      step();
      check($sformatf("vec%0d_pc", i), IF_PC, vecs[i].exp_pc);
      check($sformatf("vec%0d_valid", i), {31'b0, IF_ID_Valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_pc4", i), IF_ID_PCPlus4, vecs[i].exp_pc4);
    end

    // Multi-cycle JR stall: PC and IF/ID frozen for three cycles, then the
    // latched target is applied with no extra cycle.
    v = mk(1,0,0,1,3'd3,3'd0,0,26'h0,32'h0040_0500,32'h0, 32'h0,0,32'h0);
    for (int i = 0; i < 3; i++) begin
      apply(v);
      step();
      check($sformatf("stall%0d_pc", i), IF_PC, 32'h8000_0004);
      check($sformatf("stall%0d_valid", i), {31'b0, IF_ID_Valid}, 32'h1);
      check($sformatf("stall%0d_pc4", i), IF_ID_PCPlus4, 32'h8000_0004);
    end
    v.pcw = 1'b1; v.ifw = 1'b1; v.fl = 1'b0;
    apply(v);
    step();
    check("stall_release_pc", IF_PC, 32'h0040_0500);
    check("stall_release_valid", {31'b0, IF_ID_Valid}, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v.rst    = ($urandom_range(0, 39) != 0);
      v.pcw    = ($urandom_range(0, 4) != 0);
      v.ifw    = ($urandom_range(0, 4) != 0);
      v.fl     = ($urandom_range(0, 5) == 0);
      v.id_src = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      v.ex_src = ($urandom_range(0, 4) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      v.alu0   = $urandom_range(0, 1) == 1;
      v.jt     = 26'($urandom());
      v.rs     = $urandom();
      v.bt     = $urandom();
      apply(v);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
